// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command-driven sequencer for a WIDTH-bit bank of JK flip-flops.
// Accepts CLEAR / LOAD / TOGGLE / NOP / UP_TO / DOWN_TO over a valid/ready
// handshake. It drives the bank's J/K vectors from its FSM state, the latched
// argument and the bank's Q feedback.
// Everything runs on the falling edge of clk_i, which is the same edge the JK
// bank uses. The controller and the bank therefore move in lockstep.
// Optional macro JKC_PRESCALE_EN: inserts a PRESCALE-cycle divider between
// count steps. Target compare and abort are still evaluated every cycle.
module jk_bank_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_arg_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_UP_TO  = 3'b011;
    localparam logic [2:0] OP_DN_TO  = 3'b100;
    localparam logic [2:0] OP_TOGGLE = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_CNT_UP,
        S_CNT_DN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_arg;
    logic             r_err;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic             w_hit;
    logic             w_step;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    // Synchronous-counter toggle enables: bit i toggles when all lower bits are
    // 1 (counting up) or all lower bits are 0 (counting down). Bit 0 always toggles.
    assign w_up_t[0] = 1'b1;
    assign w_dn_t[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tog
            assign w_up_t[gi] = w_up_t[gi-1] & q_i[gi-1];
            assign w_dn_t[gi] = w_dn_t[gi-1] & ~q_i[gi-1];
        end
    endgenerate

    assign w_hit = (q_i == r_arg);

`ifdef JKC_PRESCALE_EN
    localparam int DIV_W = $clog2(PRESCALE);
    logic [DIV_W-1:0] r_div;

    // Divider runs only while counting and is held at zero otherwise, so every count starts with a full period.
    always_ff @(negedge clk_i) begin
        if (rst_i || (r_state != S_CNT_UP && r_state != S_CNT_DN)) begin
            r_div <= '0;
        end else if (r_div == DIV_W'(PRESCALE - 1)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_step = (r_div == DIV_W'(PRESCALE - 1));
`else
    assign w_step = 1'b1;
`endif

    // J/K drive: hold (0/0) unless executing an op or taking a count step; forced to hold during reset.
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (!rst_i) begin
            case (r_state)
                S_EXEC: begin
                    case (r_op)
                        OP_CLEAR: begin
                            w_k = '1;
                        end
                        OP_LOAD: begin
                            w_j = r_arg;
                            w_k = ~r_arg;
                        end
                        OP_TOGGLE: begin
                            w_j = r_arg;
                            w_k = r_arg;
                        end
                        default: begin
                            w_j = '0;
                            w_k = '0;
                        end
                    endcase
                end
                S_CNT_UP: begin
                    if (!abort_i && !w_hit && w_step) begin
                        w_j = w_up_t;
                        w_k = w_up_t;
                    end
                end
                S_CNT_DN: begin
                    if (!abort_i && !w_hit && w_step) begin
                        w_j = w_dn_t;
                        w_k = w_dn_t;
                    end
                end
                default: begin
                    w_j = '0;
                    w_k = '0;
                end
            endcase
        end
    end

    // Command FSM. The handshake and status outputs are registered alongside the state.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_arg   <= '0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_op    <= cmd_op_i;
                        r_arg   <= cmd_arg_i;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        case (cmd_op_i)
                            OP_UP_TO: begin
                                r_state <= S_CNT_UP;
                                r_err   <= 1'b0;
                            end
                            OP_DN_TO: begin
                                r_state <= S_CNT_DN;
                                r_err   <= 1'b0;
                            end
                            OP_NOP, OP_CLEAR, OP_LOAD, OP_TOGGLE: begin
                                r_state <= S_EXEC;
                                r_err   <= 1'b0;
                            end
                            default: begin
                                r_state <= S_DONE;
                                r_err   <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_CNT_UP, S_CNT_DN: begin
                    if (abort_i || w_hit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign j_o         = w_j;
    assign k_o         = w_k;
    assign cmd_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Testbench for jk_bank_ctrl with a behavioural JK bank closing the Q loop.
// Table of commands, each with an expected final Q, latency, error flag and
// first-cycle J/K. Expectations are queued at accept and checked at done_o.
// Hand sequences cover reset, abort and reset-mid-count.
`timescale 1ns/1ps
module tb_jk_bank_ctrl;

    localparam int W  = 4;
    localparam int PS = 4;
`ifdef JKC_PRESCALE_EN
    localparam int STEP_CYC = PS;
`else
    localparam int STEP_CYC = 1;
`endif

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_UP_TO  = 3'b011;
    localparam logic [2:0] OP_DN_TO  = 3'b100;
    localparam logic [2:0] OP_TOGGLE = 3'b101;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = 3'b000;
    logic [W-1:0] cmd_arg = '0;
    logic         abort = 1'b0;
    logic [W-1:0] q = '0;
    logic [W-1:0] j, k;
    logic         cmd_ready, busy, done, err;

    jk_bank_ctrl #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_arg_i   (cmd_arg),
        .abort_i     (abort),
        .q_i         (q),
        .j_o         (j),
        .k_o         (k),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank on the falling edge: Q+ = J&~Q | ~K&Q
    always @(negedge clk) q <= (j & ~q) | (~k & q);

    // kind: 0 = single EXEC op, 1 = count op, 2 = illegal op
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] arg;
        int           kind;
        int           steps;
        logic [W-1:0] exp_q;
        logic         exp_err;
        logic [W-1:0] exp_j;
        logic [W-1:0] exp_k;
    } vec_t;

    typedef struct {
        int           lat;
        logic [W-1:0] q;
        logic         err;
        int           kind;
    } exp_t;

    vec_t vecs[15];
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] arg, input int kind,
                                input int steps, input logic [W-1:0] eq, input logic ee,
                                input logic [W-1:0] ej, input logic [W-1:0] ek);
        vec_t v;
        v.op = op; v.arg = arg; v.kind = kind; v.steps = steps;
        v.exp_q = eq; v.exp_err = ee; v.exp_j = ej; v.exp_k = ek;
        return v;
    endfunction

    // Drive one command at a rising edge, accept it at the next falling edge, and return at the rising edge after accept.
    task automatic send(input logic [2:0] op, input logic [W-1:0] arg, input string name);
        int w;
        w = 0;
        @(posedge clk);
        while (!cmd_ready && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk({name, "_ready_wait"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        @(posedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    // Wait (bounded) at rising edges until done_o is seen.
    task automatic wait_done(input string name);
        int w;
        w = 0;
        while (!done && w < 300) begin
            @(negedge clk);
            @(posedge clk);
            w++;
        end
        chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(OP_LOAD,   4'hA, 0, 0, 4'hA, 1'b0, 4'hA, 4'h5);
        vecs[1]  = mk(OP_UP_TO,  4'hD, 1, 3, 4'hD, 1'b0, 4'h1, 4'h1);
        vecs[2]  = mk(OP_LOAD,   4'hE, 0, 0, 4'hE, 1'b0, 4'hE, 4'h1);
        vecs[3]  = mk(OP_UP_TO,  4'h1, 1, 3, 4'h1, 1'b0, 4'h1, 4'h1);
        vecs[4]  = mk(OP_DN_TO,  4'hE, 1, 3, 4'hE, 1'b0, 4'h1, 4'h1);
        vecs[5]  = mk(OP_LOAD,   4'h3, 0, 0, 4'h3, 1'b0, 4'h3, 4'hC);
        vecs[6]  = mk(OP_DN_TO,  4'h3, 1, 0, 4'h3, 1'b0, 4'h0, 4'h0);
        vecs[7]  = mk(OP_TOGGLE, 4'h5, 0, 0, 4'h6, 1'b0, 4'h5, 4'h5);
        vecs[8]  = mk(3'b111,    4'h9, 2, 0, 4'h6, 1'b1, 4'h0, 4'h0);
        vecs[9]  = mk(OP_CLEAR,  4'h7, 0, 0, 4'h0, 1'b0, 4'h0, 4'hF);
        vecs[10] = mk(OP_NOP,    4'h9, 0, 0, 4'h0, 1'b0, 4'h0, 4'h0);
        vecs[11] = mk(3'b110,    4'h3, 2, 0, 4'h0, 1'b1, 4'h0, 4'h0);
        vecs[12] = mk(OP_UP_TO,  4'h2, 1, 2, 4'h2, 1'b0, 4'h1, 4'h1);
        vecs[13] = mk(OP_DN_TO,  4'hF, 1, 3, 4'hF, 1'b0, 4'h3, 4'h3);
        vecs[14] = mk(OP_TOGGLE, 4'hA, 0, 0, 4'h5, 1'b0, 4'hA, 4'hA);

        // Reset: two falling edges with rst high.
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        chk("rst_j", {28'd0, j}, 32'd0);
        chk("rst_k", {28'd0, k}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            exp_t e;
            exp_t got;
            logic [W-1:0] ej, ek, pj, pk;
            int lat;
            string nm;
            nm = $sformatf("v%0d", i);
            e.kind = vecs[i].kind;
            e.q    = vecs[i].exp_q;
            e.err  = vecs[i].exp_err;
            e.lat  = (vecs[i].kind == 0) ? 1 :
                     (vecs[i].kind == 2) ? 0 : vecs[i].steps * STEP_CYC + 1;
            sb_q.push_back(e);
            send(vecs[i].op, vecs[i].arg, nm);

            // First cycle after accept: count ops under the prescaler hold on their first cycle.
            ej = vecs[i].exp_j;
            ek = vecs[i].exp_k;
            if (vecs[i].kind == 1 && STEP_CYC > 1) begin
                ej = '0;
                ek = '0;
            end
            chk({nm, "_j1"}, {28'd0, j}, {28'd0, ej});
            chk({nm, "_k1"}, {28'd0, k}, {28'd0, ek});

            lat = 0;
            pj  = 'x;
            pk  = 'x;
            while (!done && lat < 300) begin
                pj = j;
                pk = k;
                @(negedge clk);
                @(posedge clk);
                lat++;
            end
            chk({nm, "_sb_nonempty"}, (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() > 0) begin
                got = sb_q.pop_front();
                chk({nm, "_done"}, {31'd0, done}, 32'd1);
                chk({nm, "_lat"}, lat, got.lat);
                chk({nm, "_q"}, {28'd0, q}, {28'd0, got.q});
                chk({nm, "_err"}, {31'd0, err}, {31'd0, got.err});
                chk({nm, "_done_ready"}, {31'd0, cmd_ready}, 32'd0);
                chk({nm, "_done_busy"}, {31'd0, busy}, 32'd1);
                chk({nm, "_done_j"}, {28'd0, j | k}, 32'd0);
                if (got.kind == 1)
                    chk({nm, "_hold_jk"}, {28'd0, pj | pk}, 32'd0);
            end
            @(negedge clk);
            @(posedge clk);
            chk({nm, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
            chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
            chk({nm, "_idle_done"}, {31'd0, done}, 32'd0);
            $display("vec %0d op=%0b arg=%0h q=%0h lat=%0d err=%0b", i, vecs[i].op, vecs[i].arg, q, lat, err);
        end

        // Abort: count 0 -> F, abort when Q reaches 5.
        begin
            int w;
            send(OP_CLEAR, 4'h0, "ab_clr");
            wait_done("ab_clr");
            send(OP_UP_TO, 4'hF, "ab_up");
            w = 0;
            while (q != 4'h5 && w < 200) begin
                @(negedge clk);
                @(posedge clk);
                w++;
            end
            chk("ab_reach5", {28'd0, q}, 32'd5);
            abort = 1'b1;
            #1;
            chk("ab_jk", {28'd0, j | k}, 32'd0);
            @(negedge clk);
            @(posedge clk);
            abort = 1'b0;
            chk("ab_done", {31'd0, done}, 32'd1);
            chk("ab_q", {28'd0, q}, 32'd5);
            @(negedge clk);
            @(posedge clk);
            chk("ab_ready", {31'd0, cmd_ready}, 32'd1);
            $display("abort q=%0h done_seen", q);
        end

        // Reset mid-count: abandons the command with no done pulse, and Q holds.
        begin
            int dcnt;
            logic [W-1:0] qh;
            send(OP_CLEAR, 4'h0, "rm_clr");
            wait_done("rm_clr");
            send(OP_UP_TO, 4'hF, "rm_up");
            for (int c = 0; c < 3 * STEP_CYC; c++) begin
                @(negedge clk);
                @(posedge clk);
            end
            rst = 1'b1;
            #1;
            chk("rm_rst_jk", {28'd0, j | k}, 32'd0);
            @(negedge clk);
            @(posedge clk);
            rst = 1'b0;
            qh = q;
            chk("rm_ready", {31'd0, cmd_ready}, 32'd1);
            chk("rm_busy", {31'd0, busy}, 32'd0);
            dcnt = 0;
            for (int c = 0; c < 6; c++) begin
                if (done) dcnt++;
                @(negedge clk);
                @(posedge clk);
            end
            chk("rm_no_done", dcnt, 0);
            chk("rm_q_hold", {28'd0, q}, {28'd0, qh});
            $display("reset_mid q=%0h done_count=%0d", q, dcnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
